// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and count/status outputs of the countdown timer
interface countdown_timer_if #(parameter int N = 4);
  logic [N-1:0] Data;
  logic         Load;
  logic         Start;
  logic         Pause;
  logic         Auto_Reload;
  logic [N-1:0] Q;
  logic         Zero;
  logic         Done;
  logic         Busy;
  modport master (output Data, Load, Start, Pause, Auto_Reload, input Q, Zero, Done, Busy);
  modport slave  (input Data, Load, Start, Pause, Auto_Reload, output Q, Zero, Done, Busy);
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: prescaled down-counter with load, pause/resume and optional auto-reload
module countdown_timer #(
  parameter int N   = 4,
  parameter int DIV = 100000
) (
  input logic             CLK100MHZ,
  input logic             reset,
  countdown_timer_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  count_q, count_d, reload_q, reload_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d, busy_q, busy_d;
  logic          tick, last;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    tick     = 1'b0;
    last     = 1'b0;
    if (bus.Load) begin
      count_d  = bus.Data;
      reload_d = bus.Data;
      pre_d    = '0;
      state_d  = IDLE;
    end else if (state_q == RUN) begin
      if (bus.Pause) begin
        state_d = PAUSED;
      end else begin
        tick  = pre_q == PMAX;
        pre_d = tick ? '0 : pre_q + 1'b1;
        // terminal tick: reload and keep running, or stop at zero
        last  = tick && count_q == N'(1);
        if (tick && count_q > N'(1)) count_d = count_q - 1'b1;
        if (last) begin
          done_d  = 1'b1;
          count_d = bus.Auto_Reload ? reload_q : '0;
          state_d = bus.Auto_Reload ? RUN : IDLE;
        end
        if (tick && count_q == '0) state_d = IDLE;
      end
    end else if (state_q == PAUSED) begin
      state_d = (bus.Start && !bus.Pause) ? RUN : PAUSED;
    end else if (bus.Start && count_q != '0) begin
      state_d = RUN;
      pre_d   = '0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end
  assign bus.Q    = count_q;
  assign bus.Zero = count_q == '0;
  assign bus.Done = done_q;
  assign bus.Busy = busy_q;
endmodule
